// File: rtl/approx_mac_pkg.sv
// Shared types and default widths for the approximate-multiplier MAC datapath.
package approx_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 8;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

endpackage

// File: rtl/sat_add_u.sv
// Unsigned saturating adder: a + zero-extended b, clamped to all-ones on carry-out.
module sat_add_u #(
    parameter int ACC_W  = 24,
    parameter int PROD_W = 16
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    // One extra bit so the carry-out doubles as the overflow detect.
    logic [ACC_W:0] full;

    assign full = {1'b0, a} + (ACC_W+1)'(b);
    assign ovf  = full[ACC_W];
    assign sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/approx_dot_accum.sv
// Accumulates a programmed-length stream of unsigned products into one
// saturating dot-product result, with valid/ready on both sides.
module approx_dot_accum
    import approx_mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] R_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat,
    output logic              busy
);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic [ACC_W-1:0]   sum;
    logic               ovf;
    logic               sat_q;

    sat_add_u #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .a   (acc),
        .b   (R_in),
        .sum (sum),
        .ovf (ovf)
    );

    // Handshake flags decode from state only, so in_ready never depends on in_valid.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;
    assign sat       = sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            sat_q <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        sat_q <= 1'b0;
                        cnt   <= '0;
                        len_q <= len;
                        state <= (len == '0) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= sum;
                        if (ovf)
                            sat_q <= 1'b1;
                        cnt <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_dot_accum.sv
// Directed bench for approx_dot_accum: default 24-bit and 18-bit accumulators
// share one stimulus stream; results are checked from per-DUT expectation queues.
module tb_approx_dot_accum;

    typedef struct {
        logic [23:0] acc;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] r_in;
    logic        out_ready;

    logic        in_ready, out_valid, sat, busy;
    logic [23:0] acc_out;
    logic        in_ready18, out_valid18, sat18, busy18;
    logic [17:0] acc18;

    exp_t q24[$];
    exp_t q18[$];
    exp_t e24, e18;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    approx_dot_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .R_in(r_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .sat(sat), .busy(busy)
    );

    approx_dot_accum #(.ACC_W(18)) dut18 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready18), .R_in(r_in),
        .out_valid(out_valid18), .out_ready(out_ready),
        .acc_out(acc18), .sat(sat18), .busy(busy18)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [23:0] a24, input logic s24,
                              input logic [23:0] a18, input logic s18);
        q24.push_back('{acc: a24, sat: s24});
        q18.push_back('{acc: a18, sat: s18});
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] p);
        in_valid = 1'b1;
        r_in     = p;
        tick();
        in_valid = 1'b0;
        r_in     = 16'hdead;
    endtask

    // Monitors: compare whenever a result handshake is about to happen.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (q24.size() == 0) begin
                n_err++;
                $display("FAIL res24: unexpected result acc=%0d", acc_out);
            end else begin
                e24 = q24.pop_front();
                if (acc_out !== e24.acc || sat !== e24.sat) begin
                    n_err++;
                    $display("FAIL res24: got acc=%0d sat=%0d expected acc=%0d sat=%0d",
                             acc_out, sat, e24.acc, e24.sat);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid18 && out_ready) begin
            n_cmp++;
            if (q18.size() == 0) begin
                n_err++;
                $display("FAIL res18: unexpected result acc=%0d", acc18);
            end else begin
                e18 = q18.pop_front();
                if ({6'd0, acc18} !== e18.acc || sat18 !== e18.sat) begin
                    n_err++;
                    $display("FAIL res18: got acc=%0d sat=%0d expected acc=%0d sat=%0d",
                             acc18, sat18, e18.acc, e18.sat);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0;
        in_valid = 1'b0; r_in = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc",       acc_out,   0);
        chk("rst_sat",       sat,       0);
        chk("rst_busy",      busy,      0);
        rst_n = 1'b1;
        tick();

        // Continuous stream of three products.
        expect_res(24'd600, 1'b0, 24'd600, 1'b0);
        do_start(8'd3);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy",     busy,     1);
        send(16'd100); send(16'd200);
        chk("t1_no_early_valid", out_valid, 0);
        send(16'd300);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_busy_hold", busy,      1);
        tick();
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_busy",  busy,      0);

        // Same vector with in_valid pattern 1,0,0,1,0,1.
        expect_res(24'd600, 1'b0, 24'd600, 1'b0);
        do_start(8'd3);
        send(16'd100);
        tick();
        chk("t2_gap_ready", in_ready, 1);
        tick();
        send(16'd200);
        tick();
        chk("t2_gap_ready2", in_ready, 1);
        chk("t2_gap_busy",   out_valid, 0);
        send(16'd300);
        chk("t2_out_valid", out_valid, 1);
        tick();

        // Five max products: 18-bit saturates on the fifth, 24-bit does not.
        expect_res(24'd325125, 1'b0, 24'd262143, 1'b1);
        do_start(8'd5);
        send(16'd65025); send(16'd65025); send(16'd65025); send(16'd65025);
        chk("t3_acc18_pre", acc18, 260100);
        chk("t3_sat18_pre", sat18, 0);
        send(16'd65025);
        chk("t3_acc18_max", acc18, 262143);
        chk("t3_sat18",     sat18, 1);
        chk("t3_acc24",     acc_out, 325125);
        chk("t3_sat24",     sat, 0);
        tick();

        // Held result with back-pressure; start pulses in HOLD are ignored.
        out_ready = 1'b0;
        expect_res(24'd3000, 1'b0, 24'd3000, 1'b0);
        do_start(8'd2);
        send(16'd1000); send(16'd2000);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_ready", in_ready,  0);
            chk("t4_hold_acc",   acc_out,   3000);
            chk("t4_hold_sat",   sat,       0);
            if (i == 2) begin
                start = 1'b1;
                len   = 8'd3;
            end
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        start = 1'b1;
        len   = 8'd3;
        tick();
        start = 1'b0;
        chk("t4_release_valid", out_valid, 0);
        chk("t4_release_busy",  busy,      0);
        tick();
        chk("t4_start_ignored", busy, 0);

        // Zero-length vector, then a single product.
        expect_res(24'd0, 1'b0, 24'd0, 1'b0);
        do_start(8'd0);
        chk("t5_len0_valid", out_valid, 1);
        chk("t5_len0_acc",   acc_out,   0);
        tick();
        expect_res(24'd65025, 1'b0, 24'd65025, 1'b0);
        do_start(8'd1);
        send(16'd65025);
        chk("t5_len1_valid", out_valid, 1);
        tick();

        // Asynchronous reset mid-accumulation, then a clean run.
        do_start(8'd4);
        send(16'd50); send(16'd60);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",  busy,      0);
        chk("t6_rst_ready", in_ready,  0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_acc",   acc_out,   0);
        chk("t6_rst_acc18", acc18,     0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_res(24'd16, 1'b0, 24'd16, 1'b0);
        do_start(8'd2);
        send(16'd7); send(16'd9);
        chk("t6_out_valid", out_valid, 1);
        tick(); tick();

        chk("drain_q24", q24.size(), 0);
        chk("drain_q18", q18.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
